axi_to_sram: RTL and testbench
==============================

// Module: axi_to_sram
// PURPOSE
//  AXI4 slave endpoint converting axi_pkg AW/W/B/AR/R channel structs into single-port SRAM
//  beat accesses (1-cycle read latency, always granted). Sits downstream of the crossbar and
//  terminates one burst at a time; used for boot ROM/scratchpad/debug RAM.
// PARAMETERS
//  MemAddrWidth  12                  SRAM word-address width (word = StrbWidth bytes)
//  DataWidth     axi_pkg::DataWidth  data width in bits (64); StrbWidth = DataWidth/8
// PORTS
//  clk_i      in   1             clock, rising edge
//  rst_ni     in   1             asynchronous active-low reset
//  aw_i       in   aw_chan_t     write address;  aw_valid_i in 1 / aw_ready_o out 1
//  w_i        in   w_chan_t      write data;     w_valid_i  in 1 / w_ready_o  out 1
//  b_o        out  b_chan_t      write response; b_valid_o  out 1 / b_ready_i in 1
//  ar_i       in   ar_chan_t     read address;   ar_valid_i in 1 / ar_ready_o out 1
//  r_o        out  r_chan_t      read data;      r_valid_o  out 1 / r_ready_i in 1
//  mem_req_o  out  1             SRAM access strobe
//  mem_we_o   out  1             1 = write, 0 = read
//  mem_addr_o out  MemAddrWidth  word address = beat_addr[MemAddrWidth+log2(StrbWidth)-1:log2(StrbWidth)]
//  mem_wdata_o out DataWidth     write data (= w_i.data)
//  mem_be_o   out  StrbWidth     byte enables (= w_i.strb)
//  mem_rdata_i in  DataWidth     read data, valid the cycle after a read mem_req_o
// BEHAVIOUR
//  - Reset: state IDLE, all valid/ready/mem_req/mem_we outputs 0, b_o/r_o 0, prio = write.
//  - FSM: IDLE -> WRITE -> WR_RESP -> IDLE; IDLE -> READ -> IDLE. One burst in flight.
//  - IDLE: aw_ready_o/ar_ready_o high only here, at most one per cycle. AW and AR both valid:
//    pick by round-robin prio (toggles after every accepted burst; reset prio = write).
//    Accepted id/addr/len/size/burst latched; beat counter = 0.
//  - Beat address: FIXED unchanged; INCR addr += 1<<size (from addr aligned to size);
//    WRAP wraps inside a (len+1)<<size aligned window; only len 1/3/7/15 legal, else SLVERR.
//    Byte offsets below StrbWidth not used for mem_addr_o; unaligned first beat uses aligned word.
//  - WRITE: w_ready_o = 1; each w handshake -> mem_req_o=1, mem_we_o=1 same cycle (combinational
//    from w_valid_i), advance address. Beat with w.last=1 or beat count == len ends burst ->
//    WR_RESP; remaining beats after early w.last not expected (protocol error, not checked).
//  - WR_RESP: b_valid_o=1, b_o.id = latched id, resp OKAY/SLVERR; hold until b_ready_i -> IDLE.
//  - READ: mem read issued in cycle N only if output register free (r_valid_o=0 or r_ready_i=1);
//    mem_rdata_i captured at N+1 into r_o, r_valid_o=1, r.last = (beat == len). Back-to-back
//    with r_ready_i held high: 1 beat/cycle, first R beat 2 cycles after AR handshake.
//    r_o stable while r_valid_o & !r_ready_i. Last R handshake -> IDLE.
//  - Errors: size > log2(StrbWidth) or illegal WRAP -> SLVERR, no mem_req_o; writes still drain
//    all W beats, reads return len+1 beats, data 0, resp SLVERR, last on final beat.
//  - a/atop: atop != 0 -> treated as normal write, resp SLVERR, no mem access (no R beats).
//  - Reset mid-burst: async abort to IDLE, no partial response; SRAM contents retained.
// CONFIGURATION
//  AXI_TO_SRAM_WRAP_EN: defined -> WRAP bursts supported as above.
//  Not defined -> every WRAP burst is an error (SLVERR, no mem access), wrap logic removed.
// STRUCTURE
//  Shared package axi_pkg: aw_chan_t, w_chan_t, b_chan_t, ar_chan_t, r_chan_t, BURST_*, RESP_*,
//  len_t/size_t/burst_t. New helper function/constant for max size (log2 StrbWidth) lives there.
//  One sub-module: axi_burst_addr_gen (combinational next-beat address from addr/len/size/burst),
//  shared by read and write paths.
// TESTING
//  1. AW addr 0x100 len 3 size 3 INCR, 4 W beats strb 0xFF -> mem_addr 0x20..0x23 we=1, B OKAY id echoed.
//  2. AR addr 0x100 len 3 INCR, r_ready=1 -> mem reads 0x20..0x23, 4 R beats consecutive, last on 4th.
//  3. AR len 7, r_ready toggling 1/0 -> no beat lost/duplicated, r_o stable while stalled.
//  4. WRAP AR addr 0x118 len 3 size 3 -> words 0x23,0x20,0x21,0x22 (macro on); SLVERR x4 data 0 (off).
//  5. AW and AR valid same cycle from reset -> write accepted first, then read; next tie -> read first.
//  6. AR size 4 (>8 bytes) len 1 -> 2 R beats SLVERR, no mem_req; rst_ni low mid-burst -> IDLE, outputs 0.

Source files
------------

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI4 channel types, encodings and helpers
package axi_pkg;

    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef logic [IdWidth-1:0]   id_t;
    typedef logic [AddrWidth-1:0] addr_t;
    typedef logic [7:0]           len_t;
    typedef logic [2:0]           size_t;
    typedef logic [1:0]           burst_t;
    typedef logic [1:0]           resp_t;

    localparam burst_t BURST_FIXED = 2'b00;
    localparam burst_t BURST_INCR  = 2'b01;
    localparam burst_t BURST_WRAP  = 2'b10;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        len_t       len;
        size_t      size;
        burst_t     burst;
        logic [5:0] atop;
    } aw_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
    } w_chan_t;

    typedef struct packed {
        id_t   id;
        resp_t resp;
    } b_chan_t;

    typedef struct packed {
        id_t    id;
        addr_t  addr;
        len_t   len;
        size_t  size;
        burst_t burst;
    } ar_chan_t;

    typedef struct packed {
        id_t                  id;
        logic [DataWidth-1:0] data;
        resp_t                resp;
        logic                 last;
    } r_chan_t;

    // Largest beat size (log2 bytes) a bus of strb_width byte lanes can carry.
    function automatic int unsigned max_size(int unsigned strb_width);
        return $clog2(strb_width);
    endfunction

    function automatic logic wrap_len_ok(len_t len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - next-beat address for FIXED/INCR/WRAP bursts
// WRAP arithmetic only present when AXI_TO_SRAM_WRAP_EN is defined.
module axi_burst_addr_gen
    import axi_pkg::*;
(
    input  addr_t  addr_i,
    input  len_t   len_i,
    input  size_t  size_i,
    input  burst_t burst_i,
    output addr_t  next_addr_o
);

    addr_t step;
    addr_t incr_addr;
`ifdef AXI_TO_SRAM_WRAP_EN
    addr_t wrap_mask;
`else
    logic  unused_len;
    assign unused_len = ^len_i;
`endif

    always_comb begin
        step        = addr_t'(1) << size_i;
        // Unaligned first beat: later beats continue from the size-aligned address.
        incr_addr   = (addr_i & ~(step - addr_t'(1))) + step;
        next_addr_o = addr_i;
`ifdef AXI_TO_SRAM_WRAP_EN
        wrap_mask   = ((addr_t'(len_i) + addr_t'(1)) << size_i) - addr_t'(1);
`endif
        case (burst_i)
            BURST_INCR: next_addr_o = incr_addr;
`ifdef AXI_TO_SRAM_WRAP_EN
            BURST_WRAP: next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
`endif
            default:    next_addr_o = addr_i;
        endcase
    end

endmodule

// File: rtl/axi_to_sram.sv
// rtl/axi_to_sram.sv - AXI4 slave terminating one burst at a time onto a 1-cycle SRAM
// Optional WRAP burst support: AXI_TO_SRAM_WRAP_EN.
module axi_to_sram
    import axi_pkg::*;
#(
    parameter int unsigned MemAddrWidth = 12,
    parameter int unsigned DataWidth    = axi_pkg::DataWidth
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  aw_chan_t                aw_i,
    input  logic                    aw_valid_i,
    output logic                    aw_ready_o,
    input  w_chan_t                 w_i,
    input  logic                    w_valid_i,
    output logic                    w_ready_o,
    output b_chan_t                 b_o,
    output logic                    b_valid_o,
    input  logic                    b_ready_i,
    input  ar_chan_t                ar_i,
    input  logic                    ar_valid_i,
    output logic                    ar_ready_o,
    output r_chan_t                 r_o,
    output logic                    r_valid_o,
    input  logic                    r_ready_i,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [MemAddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0]    mem_wdata_o,
    output logic [DataWidth/8-1:0]  mem_be_o,
    input  logic [DataWidth-1:0]    mem_rdata_i
);

    localparam int unsigned OffW        = $clog2(DataWidth / 8);
    localparam size_t       MaxBeatSize = size_t'(max_size(DataWidth / 8));
`ifdef AXI_TO_SRAM_WRAP_EN
    localparam bit WrapEn = 1'b1;
`else
    localparam bit WrapEn = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WRITE, WR_RESP, READ} state_e;

    state_e               state_q, state_d;
    logic                 prio_q, prio_d;      // 1: read wins the next AW/AR tie
    id_t                  id_q, id_d;
    addr_t                addr_q, addr_d;
    len_t                 len_q, len_d;
    size_t                size_q, size_d;
    burst_t               burst_q, burst_d;
    logic [8:0]           cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 r_valid_q, r_valid_d;
    logic                 r_fresh_q, r_fresh_d; // r data still on mem_rdata_i, not yet held
    logic                 r_last_q, r_last_d;
    logic [DataWidth-1:0] r_data_q, r_data_d;
    addr_t                next_addr;
    logic                 pick_w;
    logic                 rd_issue;

    function automatic logic burst_err(len_t len, size_t size, burst_t burst);
        return (size > MaxBeatSize) || (burst == 2'b11) ||
               ((burst == BURST_WRAP) && (!WrapEn || !wrap_len_ok(len)));
    endfunction

    axi_burst_addr_gen u_addr_gen (
        .addr_i      (addr_q),
        .len_i       (len_q),
        .size_i      (size_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr)
    );

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        r_valid_d  = r_valid_q;
        r_fresh_d  = r_fresh_q;
        r_last_d   = r_last_q;
        r_data_d   = r_data_q;
        aw_ready_o = 1'b0;
        ar_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        b_valid_o  = 1'b0;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        rd_issue   = 1'b0;
        pick_w     = aw_valid_i && (!ar_valid_i || !prio_q);
        case (state_q)
            IDLE: begin
                aw_ready_o = pick_w;
                ar_ready_o = ar_valid_i && !pick_w;
                if (pick_w) begin
                    id_d    = aw_i.id;
                    addr_d  = aw_i.addr;
                    len_d   = aw_i.len;
                    size_d  = aw_i.size;
                    burst_d = aw_i.burst;
                    err_d   = burst_err(aw_i.len, aw_i.size, aw_i.burst) || (aw_i.atop != 6'd0);
                    cnt_d   = '0;
                    prio_d  = !prio_q;
                    state_d = WRITE;
                end else if (ar_valid_i) begin
                    id_d    = ar_i.id;
                    addr_d  = ar_i.addr;
                    len_d   = ar_i.len;
                    size_d  = ar_i.size;
                    burst_d = ar_i.burst;
                    err_d   = burst_err(ar_i.len, ar_i.size, ar_i.burst);
                    cnt_d   = '0;
                    prio_d  = !prio_q;
                    state_d = READ;
                end
            end
            WRITE: begin
                w_ready_o = 1'b1;
                if (w_valid_i) begin
                    mem_req_o = !err_q;
                    mem_we_o  = !err_q;
                    addr_d    = next_addr;
                    cnt_d     = cnt_q + 9'd1;
                    if (w_i.last || (cnt_q == {1'b0, len_q})) state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                b_valid_o = 1'b1;
                if (b_ready_i) state_d = IDLE;
            end
            READ: begin
                // Only fetch when the output slot is guaranteed free next cycle.
                rd_issue  = (cnt_q <= {1'b0, len_q}) && (!r_valid_q || r_ready_i);
                mem_req_o = rd_issue && !err_q;
                if (r_valid_q && r_ready_i) begin
                    r_valid_d = 1'b0;
                    r_fresh_d = 1'b0;
                    if (r_last_q) state_d = IDLE;
                end else if (r_valid_q && r_fresh_q) begin
                    r_data_d  = mem_rdata_i;
                    r_fresh_d = 1'b0;
                end
                if (rd_issue) begin
                    r_valid_d = 1'b1;
                    r_fresh_d = !err_q;
                    r_data_d  = '0;
                    r_last_d  = (cnt_q == {1'b0, len_q});
                    addr_d    = next_addr;
                    cnt_d     = cnt_q + 9'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            r_valid_q <= 1'b0;
            r_fresh_q <= 1'b0;
            r_last_q  <= 1'b0;
            r_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            r_valid_q <= r_valid_d;
            r_fresh_q <= r_fresh_d;
            r_last_q  <= r_last_d;
            r_data_q  <= r_data_d;
        end
    end

    assign mem_addr_o  = addr_q[MemAddrWidth+OffW-1:OffW];
    assign mem_wdata_o = w_i.data;
    assign mem_be_o    = w_i.strb;
    assign r_valid_o   = r_valid_q;

    always_comb begin
        b_o      = '0;
        b_o.id   = id_q;
        b_o.resp = err_q ? RESP_SLVERR : RESP_OKAY;
        r_o      = '0;
        r_o.id   = id_q;
        r_o.data = r_fresh_q ? mem_rdata_i : r_data_q;
        r_o.resp = err_q ? RESP_SLVERR : RESP_OKAY;
        r_o.last = r_last_q;
    end

endmodule

// File: tb/tb_axi_to_sram.sv
// tb/tb_axi_to_sram.sv - scoreboard bench for axi_to_sram against a burst-level reference model
module tb_axi_to_sram;
    import axi_pkg::*;

    logic     clk = 1'b0;
    logic     rst_ni = 1'b0;
    aw_chan_t aw_i = '0;
    logic     aw_valid_i = 1'b0, aw_ready_o;
    w_chan_t  w_i = '0;
    logic     w_valid_i = 1'b0, w_ready_o;
    b_chan_t  b_o;
    logic     b_valid_o, b_ready_i = 1'b0;
    ar_chan_t ar_i = '0;
    logic     ar_valid_i = 1'b0, ar_ready_o;
    r_chan_t  r_o;
    logic     r_valid_o, r_ready_i = 1'b0;
    logic        mem_req_o, mem_we_o;
    logic [11:0] mem_addr_o;
    logic [63:0] mem_wdata_o, mem_rdata_i;
    logic [7:0]  mem_be_o;

    always #5 clk = ~clk;

    axi_to_sram #(.MemAddrWidth(12), .DataWidth(64)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .aw_i(aw_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
        .w_i(w_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
        .b_o(b_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
        .ar_i(ar_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
        .r_o(r_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
    );

    // SRAM device: 1-cycle read latency, garbage on rdata when not reading.
    logic [63:0] sram [0:4095];
    always @(posedge clk) begin
        if (mem_req_o && mem_we_o)
            for (int b = 0; b < 8; b++)
                if (mem_be_o[b]) sram[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
        if (mem_req_o && !mem_we_o) mem_rdata_i <= sram[mem_addr_o];
        else                        mem_rdata_i <= {$urandom, $urandom};
    end

    typedef struct { bit we; logic [11:0] addr; logic [63:0] data; logic [7:0] be; } mem_exp_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] resp; bit last; } r_exp_t;
    mem_exp_t mem_q[$];
    b_exp_t   b_q[$];
    r_exp_t   r_q[$];

    logic [63:0] ref_mem [0:4095];
    bit          prio_rd = 1'b0;
    int          errors = 0, checks = 0;

    task automatic check(input bit ok, input string name, input string msg);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, msg);
        end
    endtask

    function automatic bit is_err(bit wr, logic [5:0] atop, int len, int size, int burst);
        bit wrap_en;
`ifdef AXI_TO_SRAM_WRAP_EN
        wrap_en = 1'b1;
`else
        wrap_en = 1'b0;
`endif
        if (size > 3 || burst == 3) return 1'b1;
        if (burst == 2 && (!wrap_en || !(len == 1 || len == 3 || len == 7 || len == 15))) return 1'b1;
        return wr && (atop != 6'd0);
    endfunction

    function automatic logic [11:0] beat_word(logic [31:0] a, int len, int size, int burst, int i);
        longint nb, al, ws, base, ba;
        nb = longint'(1) << size;
        al = (longint'(a) / nb) * nb;
        if (burst == 0)      ba = a;
        else if (burst == 1) ba = (i == 0) ? longint'(a) : al + i * nb;
        else begin
            ws   = (len + 1) * nb;
            base = (longint'(a) / ws) * ws;
            ba   = base + ((al - base + i * nb) % ws);
        end
        return 12'((ba / 8) % 4096);
    endfunction

    task automatic set_aw(logic [3:0] id, logic [31:0] a, int len, int size, int burst, logic [5:0] atop);
        aw_i = '{id: id, addr: a, len: 8'(len), size: 3'(size), burst: 2'(burst), atop: atop};
    endtask

    task automatic set_ar(logic [3:0] id, logic [31:0] a, int len, int size, int burst);
        ar_i = '{id: id, addr: a, len: 8'(len), size: 3'(size), burst: 2'(burst)};
    endtask

    task automatic hs_aw();
        bit got = 0, other = 0;
        int n = 0;
        aw_valid_i = 1'b1;
        while (!got && n < 200) begin
            #1; got = aw_ready_o; other |= ar_ready_o;
            @(negedge clk); n++;
        end
        aw_valid_i = 1'b0;
        check(got && !other, "aw_accept", $sformatf("aw_ready=%0d ar_ready_seen=%0d, required 1 and 0", got, other));
    endtask

    task automatic hs_ar();
        bit got = 0, other = 0;
        int n = 0;
        ar_valid_i = 1'b1;
        while (!got && n < 200) begin
            #1; got = ar_ready_o; other |= aw_ready_o;
            @(negedge clk); n++;
        end
        ar_valid_i = 1'b0;
        check(got && !other, "ar_accept", $sformatf("ar_ready=%0d aw_ready_seen=%0d, required 1 and 0", got, other));
    endtask

    task automatic do_write(logic [3:0] id, logic [31:0] a, int len, int size, int burst,
                            logic [5:0] atop, bit full_strb);
        logic [63:0] d [16];
        logic [7:0]  s [16];
        bit err;
        bit got;
        int n;
        err = is_err(1'b1, atop, len, size, burst);
        for (int i = 0; i <= len; i++) begin
            d[i] = {$urandom, $urandom};
            s[i] = full_strb ? 8'hFF : 8'($urandom);
            if (!err) begin
                mem_q.push_back('{1'b1, beat_word(a, len, size, burst, i), d[i], s[i]});
                for (int b = 0; b < 8; b++)
                    if (s[i][b]) ref_mem[beat_word(a, len, size, burst, i)][b*8 +: 8] = d[i][b*8 +: 8];
            end
        end
        b_q.push_back('{id, err ? RESP_SLVERR : RESP_OKAY});
        prio_rd = !prio_rd;
        set_aw(id, a, len, size, burst, atop);
        hs_aw();
        for (int i = 0; i <= len; i++) begin
            repeat ($urandom % 3) @(negedge clk);
            w_i = '{data: d[i], strb: s[i], last: (i == len)};
            w_valid_i = 1'b1;
            got = 0; n = 0;
            while (!got && n < 200) begin #1; got = w_ready_o; @(negedge clk); n++; end
            w_valid_i = 1'b0;
            check(got, "w_accept", $sformatf("w_ready=%0d on beat %0d, required 1", got, i));
        end
        repeat ($urandom % 3) @(negedge clk);
        b_ready_i = 1'b1;
        got = 0; n = 0;
        while (!got && n < 200) begin #1; got = b_valid_o; @(negedge clk); n++; end
        b_ready_i = 1'b0;
        check(got && b_q.size() == 0, "b_done", $sformatf("b_valid=%0d pending=%0d, required 1 and 0", got, b_q.size()));
    endtask

    // rmode: 0 random r_ready, 1 held high, 2 alternating 1/0
    task automatic do_read(logic [3:0] id, logic [31:0] a, int len, int size, int burst, int rmode, bit chk_lat);
        bit err;
        int n, first;
        logic [11:0] w;
        err = is_err(1'b0, 6'd0, len, size, burst);
        for (int i = 0; i <= len; i++) begin
            w = beat_word(a, len, size, burst, i);
            if (!err) mem_q.push_back('{1'b0, w, 64'd0, 8'd0});
            r_q.push_back('{id, err ? 64'd0 : ref_mem[w], err ? RESP_SLVERR : RESP_OKAY, i == len});
        end
        prio_rd = !prio_rd;
        set_ar(id, a, len, size, burst);
        r_ready_i = (rmode == 1);
        hs_ar();
        n = 0; first = -1;
        while (r_q.size() != 0 && n < 600) begin
            r_ready_i = (rmode == 1) ? 1'b1 : (rmode == 2) ? (n % 2 == 0) : 1'($urandom);
            #1; if (first < 0 && r_valid_o) first = n;
            @(negedge clk); n++;
        end
        r_ready_i = 1'b0;
        check(r_q.size() == 0, "r_drain", $sformatf("beats outstanding=%0d, required 0", r_q.size()));
        if (chk_lat) begin
            check(first == 1, "r_first_latency", $sformatf("first R after %0d cycles, required 1", first));
            check(n == len + 2, "r_back_to_back", $sformatf("burst took %0d cycles, required %0d", n, len + 2));
        end
    endtask

    task automatic do_tie(logic [3:0] wid, logic [31:0] wa, int wlen, logic [3:0] rid, logic [31:0] ra, int rlen);
        set_aw(wid, wa, wlen, 3, 1, 6'd0);
        set_ar(rid, ra, rlen, 3, 1);
        aw_valid_i = 1'b1;
        ar_valid_i = 1'b1;
        if (!prio_rd) begin
            do_write(wid, wa, wlen, 3, 1, 6'd0, 1'b0);
            do_read(rid, ra, rlen, 3, 1, 0, 1'b0);
        end else begin
            do_read(rid, ra, rlen, 3, 1, 0, 1'b0);
            do_write(wid, wa, wlen, 3, 1, 6'd0, 1'b0);
        end
    endtask

    task automatic check_quiet(input string name);
        check(!aw_ready_o && !ar_ready_o && !w_ready_o && !b_valid_o && !r_valid_o &&
              !mem_req_o && !mem_we_o && b_o == '0 && r_o == '0, name,
              $sformatf("awr=%0d arr=%0d wr=%0d bv=%0d rv=%0d req=%0d we=%0d b=%0h r_nonzero=%0d, required all 0",
                        aw_ready_o, ar_ready_o, w_ready_o, b_valid_o, r_valid_o, mem_req_o, mem_we_o,
                        b_o, r_o != '0));
    endtask

    // Monitor: samples just before each rising edge.
    bit      prev_stall = 1'b0;
    r_chan_t prev_r;
    always begin
        @(negedge clk); #4;
        if (!rst_ni) prev_stall = 1'b0;
        else begin
            if (aw_ready_o && ar_ready_o) check(1'b0, "dual_ready", "aw_ready and ar_ready both 1, required at most one");
            if (mem_req_o) begin
                if (mem_q.size() == 0)
                    check(1'b0, "mem_unexpected", $sformatf("mem_req we=%0d addr=%0h, required no access", mem_we_o, mem_addr_o));
                else begin
                    mem_exp_t e;
                    e = mem_q.pop_front();
                    check(mem_we_o == e.we && mem_addr_o == e.addr &&
                          (!e.we || (mem_wdata_o == e.data && mem_be_o == e.be)), "mem_access",
                          $sformatf("we=%0d addr=%0h data=%h be=%h, required we=%0d addr=%0h data=%h be=%h",
                                    mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, e.we, e.addr, e.data, e.be));
                end
            end
            if (b_valid_o && b_ready_i) begin
                if (b_q.size() == 0) check(1'b0, "b_unexpected", $sformatf("b id=%0h, required none", b_o.id));
                else begin
                    b_exp_t e;
                    e = b_q.pop_front();
                    check(b_o.id == e.id && b_o.resp == e.resp, "b_resp",
                          $sformatf("id=%0h resp=%0d, required id=%0h resp=%0d", b_o.id, b_o.resp, e.id, e.resp));
                end
            end
            if (r_valid_o && r_ready_i) begin
                if (r_q.size() == 0) check(1'b0, "r_unexpected", $sformatf("r id=%0h, required none", r_o.id));
                else begin
                    r_exp_t e;
                    e = r_q.pop_front();
                    check(r_o.id == e.id && r_o.data == e.data && r_o.resp == e.resp && r_o.last == e.last, "r_beat",
                          $sformatf("id=%0h data=%h resp=%0d last=%0d, required id=%0h data=%h resp=%0d last=%0d",
                                    r_o.id, r_o.data, r_o.resp, r_o.last, e.id, e.data, e.resp, e.last));
                end
            end
            if (prev_stall)
                check(r_valid_o && r_o == prev_r, "r_stable",
                      $sformatf("valid=%0d data=%h, required valid=1 data=%h", r_valid_o, r_o.data, prev_r.data));
            prev_stall = r_valid_o && !r_ready_i;
            prev_r = r_o;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v;
        int sz, bu, ln;
        logic [31:0] a;
        logic [5:0] at;
        for (int i = 0; i < 4096; i++) begin
            v = {$urandom, $urandom};
            sram[i] = v;
            ref_mem[i] = v;
        end
        repeat (3) @(negedge clk);
        check_quiet("reset_state");
        rst_ni = 1'b1;
        @(negedge clk);

        do_tie(4'h1, 32'h200, 1, 4'h2, 32'h200, 1);
        do_write(4'h3, 32'h300, 0, 3, 1, 6'd0, 1'b0);
        do_tie(4'h4, 32'h240, 2, 4'h5, 32'h300, 0);

        do_write(4'h5, 32'h100, 3, 3, 1, 6'd0, 1'b1);
        do_read(4'h6, 32'h100, 3, 3, 1, 1, 1'b1);
        do_read(4'h7, 32'h180, 7, 3, 1, 2, 1'b0);
        do_read(4'h8, 32'h118, 3, 3, 2, 1, 1'b0);
        do_write(4'h9, 32'h418, 3, 3, 2, 6'd0, 1'b0);
        do_read(4'hA, 32'h400, 3, 3, 1, 0, 1'b0);
        do_read(4'hB, 32'h100, 1, 4, 1, 0, 1'b0);
        do_write(4'hC, 32'h500, 2, 4, 1, 6'd0, 1'b0);
        do_write(4'hD, 32'h100, 1, 3, 1, 6'h20, 1'b0);
        do_read(4'hE, 32'h100, 1, 3, 1, 1, 1'b0);

        for (int k = 0; k < 40; k++) begin
            sz = ($urandom % 8 == 0) ? 4 : int'($urandom % 4);
            bu = int'($urandom % 3);
            if (bu == 2) ln = ($urandom % 6 == 0) ? 2 : (1 << $urandom_range(1, 4)) - 1;
            else         ln = int'($urandom % 16);
            a  = $urandom % 32'h7000;
            at = ($urandom % 10 == 0) ? 6'h20 : 6'd0;
            if ($urandom % 2) do_write(4'($urandom), a, ln, sz, bu, at, 1'b0);
            else              do_read(4'($urandom), a, ln, sz, bu, int'($urandom % 3), 1'b0);
        end

        // Abort a read burst mid-flight with an asynchronous reset.
        set_ar(4'h3, 32'h600, 7, 3, 1);
        for (int i = 0; i <= 7; i++)
            mem_q.push_back('{1'b0, beat_word(32'h600, 7, 3, 1, i), 64'd0, 8'd0});
        for (int i = 0; i <= 7; i++)
            r_q.push_back('{4'h3, ref_mem[beat_word(32'h600, 7, 3, 1, i)], RESP_OKAY, i == 7});
        r_ready_i = 1'b1;
        hs_ar();
        repeat (3) @(negedge clk);
        #2 rst_ni = 1'b0;
        #1 check_quiet("reset_mid_burst");
        r_ready_i = 1'b0;
        mem_q.delete();
        r_q.delete();
        prio_rd = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        do_tie(4'h6, 32'h700, 3, 4'h7, 32'h100, 3);
        do_read(4'h8, 32'h700, 3, 3, 1, 0, 1'b0);

        repeat (2) @(negedge clk);
        check(mem_q.size() == 0 && b_q.size() == 0 && r_q.size() == 0, "scoreboard_empty",
              $sformatf("pending mem=%0d b=%0d r=%0d, required 0", mem_q.size(), b_q.size(), r_q.size()));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
